// File: rtl/immgen_pkg.sv
// Shared constants, field positions and types for the RV32I immediate
// generator. Optional build feature: IMMGEN_ALIGN_CHECK_EN (see top level).
package immgen_pkg;

  localparam int XLEN    = 32;
  localparam int IMM_I_W = 12;
  localparam int IMM_S_W = 12;
  localparam int IMM_B_W = 13;
  localparam int IMM_J_W = 21;

  // Instruction field bit positions shared by several formats.
  localparam int SIGN_BIT  = 31;  // sign of every signed immediate
  localparam int I_LSB     = 20;  // I: inst[31:20]
  localparam int S_HI_LSB  = 25;  // S/B: inst[31:25] or inst[30:25]
  localparam int S_HI_MSB  = 30;
  localparam int S_LO_MSB  = 11;  // S: inst[11:7]
  localparam int S_LO_LSB  = 7;
  localparam int B_B11_BIT = 7;   // B: imm[11] lives in inst[7]
  localparam int B_LO_LSB  = 8;   // B: imm[4:1] = inst[11:8]
  localparam int U_LSB     = 12;  // U: inst[31:12]
  localparam int J_MID_MSB = 19;  // J: imm[19:12] = inst[19:12]
  localparam int J_MID_LSB = 12;
  localparam int J_B11_BIT = 20;  // J: imm[11] lives in inst[20]
  localparam int J_LO_MSB  = 30;  // J: imm[10:1] = inst[30:21]
  localparam int J_LO_LSB  = 21;

  typedef logic [XLEN-1:0] word_t;

  // The five sign-extended raw immediates decoded from one instruction.
  typedef struct packed {
    word_t imm_i;
    word_t imm_s;
    word_t imm_b;
    word_t imm_u;
    word_t imm_j;
  } imm_set_t;

endpackage

// File: rtl/imm_decode.sv
// Purely combinational RV32I immediate extraction: all five formats decoded
// in parallel, opcode-agnostic, each sign- or zero-filled to XLEN.
module imm_decode
  import immgen_pkg::*;
(
  input  logic [XLEN-1:0] instruction,
  output imm_set_t        imm
);

  logic sign;
  logic unused_opcode;

  assign sign = instruction[SIGN_BIT];

  // The opcode bits never contribute to any immediate.
  assign unused_opcode = ^instruction[6:0];

  // Field gathering and sign extension for each format.
  always_comb begin
    imm       = '0;
    imm.imm_i = {{(XLEN-IMM_I_W){sign}}, instruction[SIGN_BIT:I_LSB]};
    imm.imm_s = {{(XLEN-IMM_S_W){sign}}, instruction[SIGN_BIT:S_HI_LSB],
                 instruction[S_LO_MSB:S_LO_LSB]};
    imm.imm_b = {{(XLEN-IMM_B_W){sign}}, sign, instruction[B_B11_BIT],
                 instruction[S_HI_MSB:S_HI_LSB],
                 instruction[S_LO_MSB:B_LO_LSB], 1'b0};
    imm.imm_u = {instruction[SIGN_BIT:U_LSB], {U_LSB{1'b0}}};
    imm.imm_j = {{(XLEN-IMM_J_W){sign}}, sign,
                 instruction[J_MID_MSB:J_MID_LSB], instruction[J_B11_BIT],
                 instruction[J_LO_MSB:J_LO_LSB], 1'b0};
  end

endmodule

// File: rtl/immediate_generator.sv
// Registered RV32I immediate / branch-jump target stage. Decodes all five
// immediate formats, forms PC-relative targets for branches and jumps with
// silent 32-bit wrap, and presents every result one clock later.
// Optional: define IMMGEN_ALIGN_CHECK_EN to add the registered
// target_misaligned flag (bit 1 of either target set).
module immediate_generator
  import immgen_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instruction_memory_data,
  input  logic [XLEN-1:0] program_counter,
  output logic [XLEN-1:0] i_type,
  output logic [XLEN-1:0] s_type,
  output logic [XLEN-1:0] sb_type,
  output logic [XLEN-1:0] u_type,
  output logic [XLEN-1:0] uj_type
`ifdef IMMGEN_ALIGN_CHECK_EN
  ,
  output logic            target_misaligned
`endif
);

  imm_set_t imm;
  word_t    sb_next;
  word_t    uj_next;

  imm_decode u_imm_decode (
    .instruction (instruction_memory_data),
    .imm         (imm)
  );

  // Carry-out of the target adders is dropped, so targets wrap modulo 2^32.
  assign sb_next = program_counter + imm.imm_b;
  assign uj_next = program_counter + imm.imm_j;

  // Output register bank: loads every cycle, cleared asynchronously by rst.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset clears outputs without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_type  <= '0;
      s_type  <= '0;
      sb_type <= '0;
      u_type  <= '0;
      uj_type <= '0;
    end else begin
      i_type  <= imm.imm_i;
      s_type  <= imm.imm_s;
      sb_type <= sb_next;
      u_type  <= imm.imm_u;
      uj_type <= uj_next;
    end
  end

`ifdef IMMGEN_ALIGN_CHECK_EN
  logic misaligned_next;

  // A target is misaligned when it is not a multiple of four bytes.
  assign misaligned_next = sb_next[1] | uj_next[1];

  // Flag register, same latency and reset behaviour as the targets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) target_misaligned <= 1'b0;
    else     target_misaligned <= misaligned_next;
  end
`endif

endmodule

// File: tb/tb_immediate_generator.sv
// Self-checking bench for immediate_generator: directed vector table,
// reset sequences, then randomized stimulus against a bit-arithmetic model.
module tb_immediate_generator;

  logic        clk;
  logic        rst;
  logic [31:0] instruction_memory_data;
  logic [31:0] program_counter;
  logic [31:0] i_type, s_type, sb_type, u_type, uj_type;
`ifdef IMMGEN_ALIGN_CHECK_EN
  logic        target_misaligned;
`endif

  int n_cmp;
  int n_bad;

  immediate_generator dut (
    .clk                     (clk),
    .rst                     (rst),
    .instruction_memory_data (instruction_memory_data),
    .program_counter         (program_counter),
    .i_type                  (i_type),
    .s_type                  (s_type),
    .sb_type                 (sb_type),
    .u_type                  (u_type),
    .uj_type                 (uj_type)
`ifdef IMMGEN_ALIGN_CHECK_EN
    ,
    .target_misaligned       (target_misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] exp_i;
    logic [31:0] exp_s;
    logic [31:0] exp_sb;
    logic [31:0] exp_u;
    logic [31:0] exp_uj;
    logic        exp_mis;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: immediates assembled with plain shifts, masks and
  // signed offsets, then added to the PC as ordinary integers.
  function automatic logic [31:0] ref_i(input logic [31:0] x);
    return 32'($signed(x) >>> 20);
  endfunction

  function automatic logic [31:0] ref_s(input logic [31:0] x);
    int v;
    v = int'($signed(x) >>> 25) * 32 + int'((x >> 7) & 32'h1f);
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_b(input logic [31:0] x);
    int v;
    v = x[31] ? -4096 : 0;
    v += int'(((x >> 7)  & 32'h1)  * 2048);
    v += int'(((x >> 25) & 32'h3f) * 32);
    v += int'(((x >> 8)  & 32'hf)  * 2);
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_j(input logic [31:0] x);
    int v;
    v = x[31] ? -(1 << 20) : 0;
    v += int'(((x >> 12) & 32'hff)  * 4096);
    v += int'(((x >> 20) & 32'h1)   * 2048);
    v += int'(((x >> 21) & 32'h3ff) * 2);
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_u(input logic [31:0] x);
    return (x / 4096) * 4096;
  endfunction

  task automatic apply(input logic [31:0] inst, input logic [31:0] pc);
    instruction_memory_data = inst;
    program_counter         = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, ".i_type"},  i_type,  v.exp_i);
    check({tag, ".s_type"},  s_type,  v.exp_s);
    check({tag, ".sb_type"}, sb_type, v.exp_sb);
    check({tag, ".u_type"},  u_type,  v.exp_u);
    check({tag, ".uj_type"}, uj_type, v.exp_uj);
`ifdef IMMGEN_ALIGN_CHECK_EN
    check({tag, ".misaligned"}, {31'd0, target_misaligned}, {31'd0, v.exp_mis});
`endif
  endtask

  function automatic vec_t model(input logic [31:0] inst, input logic [31:0] pc);
    vec_t v;
    v.inst    = inst;
    v.pc      = pc;
    v.exp_i   = ref_i(inst);
    v.exp_s   = ref_s(inst);
    v.exp_sb  = pc + ref_b(inst);
    v.exp_u   = ref_u(inst);
    v.exp_uj  = pc + ref_j(inst);
    v.exp_mis = ((v.exp_sb % 4) >= 2) || ((v.exp_uj % 4) >= 2);
    return v;
  endfunction

  vec_t vecs[6];
  vec_t zero_v;
  vec_t va;
  vec_t vb;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    zero_v = '{default: '0};

    vecs[0] = '{32'hFDB97531, 32'hECA86420, 32'hFFFFFFDB, 32'hFFFFFFCA,
                32'hECA85BEA, 32'hFDB97000, 32'hECA1E3FA, 1'b1};
    vecs[1] = '{32'h00000013, 32'h00000100, 32'h0, 32'h0,
                32'h00000100, 32'h0, 32'h00000100, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'hFFFFF000, 32'h000007FF, 32'h000007FF,
                32'hFFFFFFFE, 32'h7FFFF000, 32'h000FEFFE, 1'b1};
    vecs[3] = '{32'h00000463, 32'hFFFFFFFC, 32'h0, 32'h00000008,
                32'h00000004, 32'h0, 32'hFFFFFFFC, 1'b0};
    vecs[4] = '{32'h00000163, 32'h00000000, 32'h0, 32'h00000002,
                32'h00000002, 32'h0, 32'h0, 1'b1};
    vecs[5] = '{32'h80000000, 32'h00001000, 32'hFFFFF800, 32'hFFFFF800,
                32'h00000000, 32'h80000000, 32'hFFF01000, 1'b0};

    // Reset asserted before any clock edge clears outputs immediately.
    rst = 1'b0;
    instruction_memory_data = 32'hFFFFFFFF;
    program_counter         = 32'h12345678;
    #2 rst = 1'b1;
    #1 check_all("reset_async", zero_v);
    @(posedge clk);
    #1 check_all("reset_hold", zero_v);
    rst = 1'b0;

    // Directed vector table.
    foreach (vecs[k]) begin
      apply(vecs[k].inst, vecs[k].pc);
      check_all($sformatf("vec%0d", k), vecs[k]);
    end

    // Reset pulse between two back-to-back inputs: in-flight B is dropped
    // while rst is high, then B reappears one edge after release.
    va = model(32'hFDB97531, 32'hECA86420);
    vb = model(32'h12345678, 32'h00400000);
    apply(va.inst, va.pc);
    check_all("pulse_a", va);
    instruction_memory_data = vb.inst;
    program_counter         = vb.pc;
    rst = 1'b1;
    #1 check_all("pulse_async", zero_v);
    @(posedge clk);
    #1 check_all("pulse_hold", zero_v);
    rst = 1'b0;
    @(posedge clk);
    #1 check_all("pulse_b", vb);

    // Randomized stimulus against the reference model.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] ri;
      logic [31:0] rp;
      ri = $urandom;
      rp = (n % 8 == 0) ? (32'hFFFFF000 | 32'($urandom_range(0, 4095))) : $urandom;
      apply(ri, rp);
      check_all("rand", model(ri, rp));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
